// File: rtl/ip_codma_fifo_pkg.sv
// Shared codma definitions: burst limit, write data engine state encoding,
// and the burst-length selection helper.
package ip_codma_fifo_pkg;

   // Largest burst the write engine will issue, in beats (power of 2, <= 15).
   localparam int unsigned CODMA_MAX_BURST = 8;

   // Write data engine states, exported so the top-level codma FSM can decode them.
   typedef enum logic [2:0] {
      WD_IDLE,
      WD_WAIT_DATA,
      WD_REQ,
      WD_DATA,
      WD_DONE,
      WD_ERR
   } wr_data_state_t;

   // Beats in the next burst: the words still owed, capped at the burst limit.
   function automatic logic [3:0] burst_len_f(input logic [31:0] rem,
                                              input int unsigned max_burst);
      logic [31:0] sel;
      sel = (rem < max_burst) ? rem : 32'(max_burst);
      return 4'(sel);
   endfunction

endpackage

// File: rtl/ip_codma_wr_data_engine.sv
// Write-side data phase engine: waits until the FIFO holds a whole burst,
// requests the bus, then streams the burst out of the FIFO without bubbles.
module ip_codma_wr_data_engine
   import ip_codma_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned MAX_BURST = CODMA_MAX_BURST
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_words_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   input  logic [DATA_W-1:0] fifo_data_i,
   input  logic [7:0]        fifo_count_i,
   output logic              fifo_rd_o,
   output logic              wr_req_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [3:0]        wr_len_o,
   input  logic              wr_grant_i,
   output logic              wr_valid_o,
   output logic [DATA_W-1:0] wr_data_o,
   input  logic              wr_ready_i,
   input  logic              wr_error_i
);

   wr_data_state_t    r_state;
   wr_data_state_t    w_next_state;

   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_rem;
   logic [3:0]        r_beat_cnt;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [3:0]        r_wr_len;
   logic              r_busy;

   logic [3:0]        w_burst_len;
   logic              w_data_room;
   logic              w_beat_acc;
   logic              w_last_beat;
   logic [LEN_W-1:0]  w_rem_next;
   logic              w_wr_req;
   logic              w_wr_valid;
   logic              w_fifo_rd;
   logic              w_done;
   logic              w_error;

   assign w_burst_len = burst_len_f(32'(r_rem), MAX_BURST);
   assign w_data_room = (fifo_count_i >= {4'd0, w_burst_len});
   assign w_beat_acc  = (r_state == WD_DATA) && wr_ready_i;
   assign w_last_beat = w_beat_acc && (r_beat_cnt == (r_wr_len - 4'd1));
   assign w_rem_next  = r_rem - LEN_W'(r_wr_len);

   // State register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of block ordering.
      if (reset_i) begin
         r_state <= WD_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      w_next_state = r_state;
      w_wr_req     = 1'b0;
      w_wr_valid   = 1'b0;
      w_fifo_rd    = 1'b0;
      w_done       = 1'b0;
      w_error      = 1'b0;
      unique case (r_state)
         WD_IDLE: begin
            if (start_i) begin
               w_next_state = (len_words_i == '0) ? WD_DONE : WD_WAIT_DATA;
            end
         end
         WD_WAIT_DATA: begin
            if (w_data_room) begin
               w_next_state = WD_REQ;
            end
         end
         WD_REQ: begin
            w_wr_req = 1'b1;
            if (wr_grant_i) begin
               w_next_state = WD_DATA;
            end
         end
         WD_DATA: begin
            w_wr_valid = 1'b1;
            if (wr_ready_i) begin
               // The beat is popped even when it carries an error response.
               w_fifo_rd = 1'b1;
               if (wr_error_i) begin
                  w_next_state = WD_ERR;
               end else if (w_last_beat) begin
                  w_next_state = (w_rem_next == '0) ? WD_DONE : WD_WAIT_DATA;
               end
            end
         end
         WD_DONE: begin
            w_done       = 1'b1;
            w_next_state = WD_IDLE;
         end
         WD_ERR: begin
            w_error      = 1'b1;
            w_next_state = WD_IDLE;
         end
         default: begin
            w_next_state = WD_IDLE;
         end
      endcase
   end

   // Transfer bookkeeping: running address, words still owed, beat counter,
   // and the per-burst request fields.
   always_ff @(posedge clk_i) begin
      // NOTE: the datapath is reset as well as the FSM, so the request fields
      // read 0 after reset rather than echoing an abandoned burst.
      if (reset_i) begin
         r_addr     <= '0;
         r_rem      <= '0;
         r_beat_cnt <= '0;
         r_wr_addr  <= '0;
         r_wr_len   <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_busy <= (w_next_state != WD_IDLE);
         case (r_state)
            WD_IDLE: begin
               if (start_i && (len_words_i != '0)) begin
                  r_addr <= dst_addr_i & ~ADDR_W'(3);
                  r_rem  <= len_words_i;
               end
            end
            WD_WAIT_DATA: begin
               if (w_data_room) begin
                  r_wr_len  <= w_burst_len;
                  r_wr_addr <= r_addr;
               end
            end
            WD_REQ: begin
               if (wr_grant_i) begin
                  r_beat_cnt <= '0;
               end
            end
            WD_DATA: begin
               if (w_beat_acc) begin
                  r_beat_cnt <= r_beat_cnt + 4'd1;
                  if (w_last_beat && !wr_error_i) begin
                     // Address wraps modulo 2^ADDR_W; no boundary handling.
                     r_addr <= r_addr + ADDR_W'({r_wr_len, 2'b00});
                     r_rem  <= w_rem_next;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = w_done;
   assign error_o    = w_error;
   assign fifo_rd_o  = w_fifo_rd;
   assign wr_req_o   = w_wr_req;
   assign wr_addr_o  = r_wr_addr;
   assign wr_len_o   = r_wr_len;
   assign wr_valid_o = w_wr_valid;
   assign wr_data_o  = fifo_data_i;

endmodule

// File: tb/tb_ip_codma_wr_data_engine.sv
// Self-checking bench for ip_codma_wr_data_engine: a queue-based FIFO model,
// a bus slave with selectable grant/ready behaviour, and a transfer-level
// reference that splits each transfer into expected bursts arithmetically.
module tb_ip_codma_wr_data_engine;

   localparam int MAXB = 8;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic [31:0] dst_addr_i;
   logic [15:0] len_words_i;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic [31:0] fifo_data_i;
   logic [7:0]  fifo_count_i;
   logic        fifo_rd_o;
   logic        wr_req_o;
   logic [31:0] wr_addr_o;
   logic [3:0]  wr_len_o;
   logic        wr_grant_i;
   logic        wr_valid_o;
   logic [31:0] wr_data_o;
   logic        wr_ready_i;
   logic        wr_error_i;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] fifo_q[$];
   logic [31:0] stream[$];

   ip_codma_wr_data_engine #(
      .DATA_W   (32),
      .ADDR_W   (32),
      .LEN_W    (16),
      .MAX_BURST(MAXB)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .start_i     (start_i),
      .dst_addr_i  (dst_addr_i),
      .len_words_i (len_words_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .error_o     (error_o),
      .fifo_data_i (fifo_data_i),
      .fifo_count_i(fifo_count_i),
      .fifo_rd_o   (fifo_rd_o),
      .wr_req_o    (wr_req_o),
      .wr_addr_o   (wr_addr_o),
      .wr_len_o    (wr_len_o),
      .wr_grant_i  (wr_grant_i),
      .wr_valid_o  (wr_valid_o),
      .wr_data_o   (wr_data_o),
      .wr_ready_i  (wr_ready_i),
      .wr_error_i  (wr_error_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word();
      logic [31:0] w;
      w = $urandom;
      fifo_q.push_back(w);
      stream.push_back(w);
   endtask

   task automatic drive_fifo();
      fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
      fifo_count_i = (fifo_q.size() > 255) ? 8'd255 : 8'(fifo_q.size());
   endtask

   // One transfer. mode: 0 random bus + stray starts, 1 grant/ready high,
   // 2 grant high and ready toggling. err_at: 1-based beat carrying an error (0 none).
   task automatic run_xfer(input int len, input logic [31:0] addr, input int err_at,
                           input int pre, input int hold, input int mode);
      logic [31:0] exp_addr[$];
      int          exp_len[$];
      logic [31:0] a;
      logic [31:0] prev_data;
      int rem, b, exp_bursts, exp_pops, bidx, beats, beat_in_burst, dones, errs, n_rd;
      int cyc, first_beat_cyc, last_beat_cyc, req_cyc, full_cyc;
      bit in_data, next_in_data, pop_pend, finished, prev_stall, timed;

      timed = (mode == 1) && (pre >= len) && (hold == 0);
      rem   = len;
      a     = {addr[31:2], 2'b00};
      while (rem > 0) begin
         b = (rem < MAXB) ? rem : MAXB;
         exp_addr.push_back(a);
         exp_len.push_back(b);
         a   = a + 32'(4 * b);
         rem = rem - b;
      end
      exp_bursts = (err_at > 0) ? (err_at + MAXB - 1) / MAXB : exp_len.size();
      exp_pops   = (err_at > 0) ? err_at : len;

      bidx = 0; beats = 0; beat_in_burst = 0; dones = 0; errs = 0; n_rd = 0;
      cyc = 0; first_beat_cyc = -1; last_beat_cyc = -100; req_cyc = -1; full_cyc = -1;
      in_data = 0; next_in_data = 0; pop_pend = 0; finished = 0; prev_stall = 0;
      prev_data = '0;

      fifo_q.delete();
      stream.delete();
      for (int i = 0; i < pre; i++) push_word();
      drive_fifo();
      wr_grant_i  = 1'b0;
      wr_ready_i  = 1'b0;
      wr_error_i  = 1'b0;
      dst_addr_i  = addr;
      len_words_i = 16'(len);
      start_i     = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;

      while (!finished && cyc < 3000) begin
         cyc++;
         if (pop_pend) begin
            void'(fifo_q.pop_front());
            pop_pend = 0;
         end
         if (cyc > hold && stream.size() < len && (mode != 0 || $urandom_range(0, 2) != 0))
            push_word();
         drive_fifo();
         if (full_cyc < 0 && int'(fifo_count_i) >= exp_len[0]) full_cyc = cyc;

         case (mode)
            1: begin
               wr_grant_i = 1'b1;
               wr_ready_i = 1'b1;
            end
            2: begin
               wr_grant_i = 1'b1;
               wr_ready_i = cyc[0];
            end
            default: begin
               wr_grant_i = ($urandom_range(0, 1) == 1);
               wr_ready_i = ($urandom_range(0, 2) != 0);
            end
         endcase
         wr_error_i = in_data && wr_ready_i && (beats + 1 == err_at);
         start_i    = (mode == 0) && ($urandom_range(0, 7) == 0);
         if (start_i) begin
            dst_addr_i  = $urandom;
            len_words_i = 16'($urandom_range(0, 50));
         end
         #1;

         check("busy", 64'(busy_o), 64'd1);
         check("wr_valid", 64'(wr_valid_o), 64'(in_data));
         check("fifo_rd", 64'(fifo_rd_o), 64'(in_data && wr_ready_i));
         if (in_data && prev_stall) check("data_hold", 64'(wr_data_o), 64'(prev_data));

         if (wr_req_o) begin
            check("req_bus_idle", 64'(in_data), 64'd0);
            check("req_idx", 64'(bidx < exp_bursts), 64'd1);
            if (bidx < exp_bursts) begin
               check("wr_addr", 64'(wr_addr_o), 64'(exp_addr[bidx]));
               check("wr_len", 64'(wr_len_o), 64'(exp_len[bidx]));
               check("room", 64'(int'(fifo_count_i) >= exp_len[bidx]), 64'd1);
            end
            if (req_cyc < 0) req_cyc = cyc;
            if (wr_grant_i) begin
               next_in_data  = 1;
               beat_in_burst = 0;
            end
         end

         if (in_data && wr_ready_i) begin
            check("wr_data", 64'(wr_data_o),
                  (beats < stream.size()) ? 64'(stream[beats]) : 64'hFFFF_FFFF_FFFF_FFFF);
            if (beats == 0) first_beat_cyc = cyc;
            else if (timed && beat_in_burst == 0) check("burst_gap", 64'(cyc - last_beat_cyc), 64'd3);
            beats++;
            beat_in_burst++;
            pop_pend = 1;
            if (wr_error_i || (bidx < exp_bursts && beat_in_burst == exp_len[bidx])) begin
               next_in_data  = 0;
               bidx++;
               last_beat_cyc = cyc;
            end
         end

         if (fifo_rd_o) n_rd++;
         if (done_o || error_o) begin
            finished = 1;
            check("end_latency", 64'(cyc - last_beat_cyc), 64'd1);
         end
         if (done_o) dones++;
         if (error_o) errs++;
         prev_stall = in_data && !wr_ready_i;
         prev_data  = wr_data_o;
         in_data    = next_in_data;
         @(posedge clk_i); #1;
      end

      start_i    = 1'b0;
      wr_grant_i = 1'b0;
      wr_ready_i = 1'b0;
      wr_error_i = 1'b0;
      if (pop_pend) void'(fifo_q.pop_front());
      drive_fifo();

      check("finished", 64'(finished), 64'd1);
      check("beats", 64'(beats), 64'(exp_pops));
      check("pops", 64'(n_rd), 64'(exp_pops));
      check("bursts", 64'(bidx), 64'(exp_bursts));
      check("done_cnt", 64'(dones), (err_at > 0) ? 64'd0 : 64'd1);
      check("err_cnt", 64'(errs), (err_at > 0) ? 64'd1 : 64'd0);
      if (timed) check("first_beat", 64'(first_beat_cyc), 64'd3);
      if (hold > 0) check("req_after_fill", 64'(req_cyc - full_cyc), 64'd1);
      #1;
      check("busy_fall", 64'(busy_o), 64'd0);
      check("done_pulse", 64'(done_o), 64'd0);
      check("error_pulse", 64'(error_o), 64'd0);
      @(posedge clk_i); #1;
   endtask

   task automatic check_reset_outputs(input string phase);
      check({phase, "_busy"}, 64'(busy_o), 64'd0);
      check({phase, "_done"}, 64'(done_o), 64'd0);
      check({phase, "_error"}, 64'(error_o), 64'd0);
      check({phase, "_fifo_rd"}, 64'(fifo_rd_o), 64'd0);
      check({phase, "_req"}, 64'(wr_req_o), 64'd0);
      check({phase, "_valid"}, 64'(wr_valid_o), 64'd0);
      check({phase, "_addr"}, 64'(wr_addr_o), 64'd0);
      check({phase, "_len"}, 64'(wr_len_o), 64'd0);
   endtask

   initial begin
      int          cnt;
      int          len;
      int          err;
      logic [31:0] addr;

      reset_i     = 1'b1;
      start_i     = 1'b0;
      dst_addr_i  = '0;
      len_words_i = '0;
      wr_grant_i  = 1'b1;
      wr_ready_i  = 1'b1;
      wr_error_i  = 1'b0;
      drive_fifo();
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_outputs("rst");
      reset_i    = 1'b0;
      wr_grant_i = 1'b0;
      wr_ready_i = 1'b0;
      @(posedge clk_i); #1;

      // Zero-length transfer: done on the next cycle, no bus activity.
      start_i     = 1'b1;
      dst_addr_i  = 32'h0000_1234;
      len_words_i = 16'd0;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("len0_done", 64'(done_o), 64'd1);
      check("len0_busy", 64'(busy_o), 64'd1);
      check("len0_req", 64'(wr_req_o), 64'd0);
      check("len0_valid", 64'(wr_valid_o), 64'd0);
      @(posedge clk_i); #1;
      check("len0_done_end", 64'(done_o), 64'd0);
      check("len0_busy_end", 64'(busy_o), 64'd0);

      // Directed transfers.
      run_xfer(5, 32'h0000_1000, 0, 5, 0, 1);
      run_xfer(20, 32'h0000_2000, 0, 20, 0, 1);
      run_xfer(20, 32'h0000_2000, 0, 8, 0, 1);
      run_xfer(8, 32'h0000_3000, 0, 7, 10, 1);
      run_xfer(4, 32'h0000_5000, 0, 4, 0, 2);
      run_xfer(8, 32'h0000_4000, 3, 8, 0, 1);
      run_xfer(12, 32'hFFFF_FFF0, 0, 12, 0, 1);
      run_xfer(9, 32'h0000_6003, 0, 9, 0, 1);

      // Randomized transfers.
      for (int t = 0; t < 30; t++) begin
         len  = $urandom_range(1, 40);
         addr = $urandom;
         err  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
         run_xfer(len, addr, err, $urandom_range(0, len), $urandom_range(0, 5), 0);
      end

      // Reset in the middle of a data phase.
      fifo_q.delete();
      stream.delete();
      for (int i = 0; i < 8; i++) push_word();
      drive_fifo();
      wr_grant_i  = 1'b1;
      wr_ready_i  = 1'b1;
      start_i     = 1'b1;
      dst_addr_i  = 32'h0000_7000;
      len_words_i = 16'd8;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cnt = 0;
      while (!wr_valid_o && cnt < 10) begin
         @(posedge clk_i); #1;
         cnt++;
      end
      check("reach_data", 64'(wr_valid_o), 64'd1);
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      check_reset_outputs("mid_rst");
      reset_i    = 1'b0;
      wr_grant_i = 1'b0;
      wr_ready_i = 1'b0;
      @(posedge clk_i); #1;
      check("post_rst_busy", 64'(busy_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
